gpio_pad_ctrl: RTL and testbench
================================

# gpio_pad_ctrl

Parametrised multi-channel controller for bidirectional pad cells with C/I/OEN/REN pins. It sits between the core register bus and the pad ring. Per channel it drives the pad data (I), the active-low output enable (OEN) and the active-low pull enable (REN). It also synchronises and debounces the pad input (C), and raises a maskable edge interrupt.

## Interface
- CH, 8, number of pad channels (1..32)
- DB_W, 4, debounce counter width; requires CH >= DB_W
- SYNC_STAGES, 2, input synchroniser depth (>= 2)

- clk  in  1  single clock for all state
- rst  in  1  synchronous, active-high reset
- cfg_we  in  1  register write strobe
- cfg_re  in  1  register read strobe
- cfg_addr  in  3  register select
- cfg_wdata  in  CH  write data
- cfg_rdata  out  CH  read data, registered
- pad_c  in  CH  pad receiver outputs (asynchronous)
- pad_i  out  CH  pad driver data
- pad_oen  out  CH  pad output enable, 0 = drive
- pad_ren  out  CH  pad pull enable, 0 = pull on
- irq  out  1  OR of enabled pending status, registered

## Operation
- Clock, reset and polarity are fixed: one clock `clk`; reset `rst` is synchronous and active-high.
- Register map (address: name, reset value):
  - 0: OUT, 0
  - 1: DIR (1 = output), 0
  - 2: PULLEN, all 1
  - 3: IN, read-only debounced value, 0
  - 4: IRQ_EN, 0
  - 5: IRQ_STAT, write-1-to-clear, 0
  - 6: EDGE_SEL (1 = rising, 0 = falling), 0
  - 7: DB_THRESH, bits [DB_W-1:0], 0
- Writes to address 3 are ignored.
- DB_THRESH reads back zero-extended.
- Pad outputs are straight register images: pad_i = OUT, pad_oen = ~DIR, pad_ren = ~PULLEN.
- Reset pad state: all channels are inputs, pulls on, pad_i = 0.
- Synchroniser: SYNC_STAGES-deep flop chain per channel, reset to 0; its output is s.
- Debounce, per channel, holds stable value d (= IN bit) and counter cnt (DB_W bits). Let T = max(DB_THRESH, 1).
  - s == d: cnt <= 0.
  - s != d and cnt >= T-1: d <= s, cnt <= 0.
  - Otherwise: cnt <= cnt + 1.
- Consequence: s must differ from d for T consecutive cycles before d changes.
- A DB_THRESH write takes effect the next cycle. Counters are not cleared. A channel whose cnt >= new T-1 updates on its next mismatch cycle.
- Edge event: d changes with new d == EDGE_SEL bit. This sets the IRQ_STAT bit regardless of IRQ_EN.
- Clearing IRQ_STAT: writing 1 clears a bit. If a W1C and an event hit the same bit in the same cycle, set wins.
- irq <= |(IRQ_STAT & IRQ_EN).
- Reset behaviour: d = 0 and EDGE_SEL = falling, so a pad that is high at reset produces a rising transition only. No status is set after reset.
- A mid-operation reset clears all state within the asserting cycle, including in-flight debounce counts.

## Timing
- Write at edge k: the register and the corresponding pad_i/pad_oen/pad_ren change at edge k (visible after k).
- Read: cfg_re at edge k gives cfg_rdata valid after edge k and held until the next read.
  - cfg_rdata resets to 0.
  - A simultaneous read and write of the same address returns the old value.
- Input latency: a pad_c change first sampled at edge k reaches s after edge k+SYNC_STAGES-1.
- d updates at edge k+SYNC_STAGES-1+T, provided the pad stays stable.
- IRQ_STAT sets at the same edge as d; irq asserts one edge later.
- A glitch shorter than T cycles at s leaves d unchanged and cnt returns to 0.
- irq drops one edge after the W1C write (or after the IRQ_EN clear).

## Test plan
- Reset: after rst, pad_oen = 0xFF, pad_ren = 0x00, pad_i = 0x00, irq = 0, all reads return reset values.
- Output path: write DIR = 0x0F, OUT = 0x05 → pad_oen = 0xF0, pad_i = 0x05 on the edge after each write; read OUT returns 0x05 one cycle after cfg_re.
- Debounce, DB_THRESH = 4, SYNC_STAGES = 2:
  - pad_c[0] high for 3 cycles, then low → IN stays 0.
  - pad_c[0] held high → IN[0] = 1 exactly 5 edges after first sample.
- Edge interrupt: EDGE_SEL = 0x01, IRQ_EN = 0x01, rising edge on channel 0 after debounce → IRQ_STAT = 0x01, irq = 1 one cycle later.
  - A falling edge on channel 1 sets nothing.
- W1C collision: write IRQ_STAT = 0x01 in the same cycle a new channel-0 event occurs → bit stays 1 and irq stays 1.
  - A later W1C → irq = 0 one cycle after.
- Mid-operation reset: assert rst while cnt = 2 on a channel → cnt, d and IRQ_STAT all cleared.
  - The pad held high afterward gives IN = 1 with no status set (EDGE_SEL reset to falling).

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl: register-mapped controller for bidirectional pad cells.
// Drives pad data / output enable / pull enable straight from registers,
// synchronises and debounces the pad receiver outputs, and flags
// selectable-polarity edges as maskable interrupts.
module gpio_pad_ctrl #(
   parameter int CH          = 8,
   parameter int DB_W        = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cfg_we,
   input  logic          cfg_re,
   input  logic [2:0]    cfg_addr,
   input  logic [CH-1:0] cfg_wdata,
   output logic [CH-1:0] cfg_rdata,
   input  logic [CH-1:0] pad_c,
   output logic [CH-1:0] pad_i,
   output logic [CH-1:0] pad_oen,
   output logic [CH-1:0] pad_ren,
   output logic          irq
);

   localparam logic [2:0] ADDR_OUT       = 3'd0;
   localparam logic [2:0] ADDR_DIR       = 3'd1;
   localparam logic [2:0] ADDR_PULLEN    = 3'd2;
   localparam logic [2:0] ADDR_IN        = 3'd3;
   localparam logic [2:0] ADDR_IRQ_EN    = 3'd4;
   localparam logic [2:0] ADDR_IRQ_STAT  = 3'd5;
   localparam logic [2:0] ADDR_EDGE_SEL  = 3'd6;
   localparam logic [2:0] ADDR_DB_THRESH = 3'd7;

   localparam logic [DB_W-1:0] CNT_ONE = {{(DB_W-1){1'b0}}, 1'b1};

   logic [CH-1:0]   out_reg;
   logic [CH-1:0]   dir_reg;
   logic [CH-1:0]   pullen_reg;
   logic [CH-1:0]   irq_en_reg;
   logic [CH-1:0]   edge_sel_reg;
   logic [DB_W-1:0] db_thresh_reg;
   logic [CH-1:0]   irq_stat_reg;
   logic [CH-1:0]   irq_stat_next;
   logic [CH-1:0]   in_reg;
   logic [CH-1:0]   in_next;
   logic [CH-1:0]   rdata_reg;
   logic [CH-1:0]   rdata_next;
   logic            irq_reg;

   logic [CH-1:0]   sync_reg [SYNC_STAGES];
   logic [CH-1:0]   sync_s;
   logic [DB_W-1:0] thresh_m1;
   logic [CH-1:0]   edge_evt;
   logic [CH-1:0]   w1c_mask;

   // Pads are pure register images; no extra pipelining toward the ring.
   assign pad_i     = out_reg;
   assign pad_oen   = ~dir_reg;
   assign pad_ren   = ~pullen_reg;
   assign cfg_rdata = rdata_reg;
   assign irq       = irq_reg;

   // Writable configuration registers (IN and IRQ_STAT handled elsewhere).
   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg       <= '0;
         dir_reg       <= '0;
         pullen_reg    <= '1;
         irq_en_reg    <= '0;
         edge_sel_reg  <= '0;
         db_thresh_reg <= '0;
      end else if (cfg_we) begin
         case (cfg_addr)
            ADDR_OUT:       out_reg       <= cfg_wdata;
            ADDR_DIR:       dir_reg       <= cfg_wdata;
            ADDR_PULLEN:    pullen_reg    <= cfg_wdata;
            ADDR_IRQ_EN:    irq_en_reg    <= cfg_wdata;
            ADDR_EDGE_SEL:  edge_sel_reg  <= cfg_wdata;
            ADDR_DB_THRESH: db_thresh_reg <= cfg_wdata[DB_W-1:0];
            default: ;
         endcase
      end
   end

   // Metastability chain for the asynchronous pad receiver outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= '0;
         end
      end else begin
         sync_reg[0] <= pad_c;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_reg[i] <= sync_reg[i-1];
         end
      end
   end

   assign sync_s = sync_reg[SYNC_STAGES-1];

   // Effective threshold minus one; a zero threshold behaves like one.
   always_comb begin
      thresh_m1 = '0;
      if (db_thresh_reg != '0) begin
         thresh_m1 = db_thresh_reg - CNT_ONE;
      end
   end

   // Per-channel debounce: count consecutive mismatch cycles, accept the
   // new level once the count reaches the threshold.
   genvar gi;
   generate
      for (gi = 0; gi < CH; gi++) begin : g_db
         logic [DB_W-1:0] cnt_reg;
         logic            mismatch;
         logic            accept;

         assign mismatch    = sync_s[gi] != in_reg[gi];
         assign accept      = mismatch && (cnt_reg >= thresh_m1);
         assign in_next[gi] = accept ? sync_s[gi] : in_reg[gi];

         // Mismatch counter; cleared on agreement or on acceptance.
         always_ff @(posedge clk) begin
            if (rst) begin
               cnt_reg <= '0;
            end else if (!mismatch || accept) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_reg + CNT_ONE;
            end
         end
      end
   endgenerate

   // An event is a change of the debounced level into the selected polarity.
   assign edge_evt = (in_next ^ in_reg) & ~(in_next ^ edge_sel_reg);
   assign w1c_mask = (cfg_we && (cfg_addr == ADDR_IRQ_STAT)) ? cfg_wdata : '0;

   // Set has priority over a same-cycle write-1-to-clear.
   always_comb begin
      irq_stat_next = (irq_stat_reg & ~w1c_mask) | edge_evt;
   end

   // Debounced input value, status bits and the registered interrupt line.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_reg       <= '0;
         irq_stat_reg <= '0;
         irq_reg      <= 1'b0;
      end else begin
         in_reg       <= in_next;
         irq_stat_reg <= irq_stat_next;
         irq_reg      <= |(irq_stat_reg & irq_en_reg);
      end
   end

   // Read multiplexer; sees pre-write values so a same-cycle write is not visible.
   always_comb begin
      rdata_next = '0;
      case (cfg_addr)
         ADDR_OUT:       rdata_next = out_reg;
         ADDR_DIR:       rdata_next = dir_reg;
         ADDR_PULLEN:    rdata_next = pullen_reg;
         ADDR_IN:        rdata_next = in_reg;
         ADDR_IRQ_EN:    rdata_next = irq_en_reg;
         ADDR_IRQ_STAT:  rdata_next = irq_stat_reg;
         ADDR_EDGE_SEL:  rdata_next = edge_sel_reg;
         ADDR_DB_THRESH: rdata_next[DB_W-1:0] = db_thresh_reg;
         default:        rdata_next = '0;
      endcase
   end

   // Read data is captured on the strobe and held until the next read.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_reg <= '0;
      end else if (cfg_re) begin
         rdata_reg <= rdata_next;
      end
   end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// tb_gpio_pad_ctrl: directed-vector bench for gpio_pad_ctrl with CH=8,
// DB_W=4, SYNC_STAGES=2. Inputs change 1 time unit after a rising edge and
// outputs are sampled at the same point.
module tb_gpio_pad_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cfg_we;
   logic       cfg_re;
   logic [2:0] cfg_addr;
   logic [7:0] cfg_wdata;
   logic [7:0] cfg_rdata;
   logic [7:0] pad_c;
   logic [7:0] pad_i;
   logic [7:0] pad_oen;
   logic [7:0] pad_ren;
   logic       irq;

   int checks_total  = 0;
   int checks_passed = 0;

   gpio_pad_ctrl #(.CH(8), .DB_W(4), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_re    (cfg_re),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .cfg_rdata (cfg_rdata),
      .pad_c     (pad_c),
      .pad_i     (pad_i),
      .pad_oen   (pad_oen),
      .pad_ren   (pad_ren),
      .irq       (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_total++;
      if (got === exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [2:0] a, input logic [7:0] v);
      cfg_addr  = a;
      cfg_wdata = v;
      cfg_we    = 1'b1;
      tick();
      cfg_we    = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, output logic [7:0] v);
      cfg_addr = a;
      cfg_re   = 1'b1;
      tick();
      cfg_re   = 1'b0;
      v        = cfg_rdata;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      logic [7:0] v;
      logic [7:0] rst_exp [8];
      rst_exp = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

      rst = 1'b1; cfg_we = 1'b0; cfg_re = 1'b0;
      cfg_addr = '0; cfg_wdata = '0; pad_c = '0;
      ticks(2);
      rst = 1'b0;

      // Reset state
      check("rst_pad_oen", pad_oen, 8'hFF);
      check("rst_pad_ren", pad_ren, 8'h00);
      check("rst_pad_i", pad_i, 8'h00);
      check("rst_irq", irq, 1'b0);
      check("rst_rdata", cfg_rdata, 8'h00);
      for (int a = 0; a < 8; a++) begin
         rd(a[2:0], v);
         check($sformatf("rst_rd%0d", a), v, rst_exp[a]);
      end

      // Output path
      wr(3'd1, 8'h0F);
      check("dir_pad_oen", pad_oen, 8'hF0);
      wr(3'd0, 8'h05);
      check("out_pad_i", pad_i, 8'h05);
      rd(3'd0, v);
      check("rd_out", v, 8'h05);
      wr(3'd2, 8'h3C);
      check("pullen_pad_ren", pad_ren, 8'hC3);
      rd(3'd2, v);
      check("rd_pullen", v, 8'h3C);

      // Simultaneous read and write of OUT returns the old value
      cfg_addr = 3'd0; cfg_wdata = 8'hAA; cfg_we = 1'b1; cfg_re = 1'b1;
      tick();
      cfg_we = 1'b0; cfg_re = 1'b0;
      check("rw_old", cfg_rdata, 8'h05);
      check("rw_pad_i", pad_i, 8'hAA);
      rd(3'd0, v);
      check("rw_new", v, 8'hAA);

      // IN is read-only; DB_THRESH is truncated to DB_W bits
      wr(3'd3, 8'hFF);
      rd(3'd3, v);
      check("in_ro", v, 8'h00);
      wr(3'd7, 8'hFF);
      rd(3'd7, v);
      check("thresh_trunc", v, 8'h0F);
      wr(3'd7, 8'h04);
      rd(3'd7, v);
      check("thresh4", v, 8'h04);

      // Glitch of 3 cycles with T=4 is rejected
      pad_c = 8'h01;
      ticks(3);
      pad_c = 8'h00;
      ticks(8);
      rd(3'd3, v);
      check("glitch_in", v, 8'h00);

      // Rising edge on channel 0, exact latency and irq one edge later
      wr(3'd6, 8'h01);
      wr(3'd4, 8'h01);
      pad_c = 8'h01;
      cfg_addr = 3'd3;
      cfg_re = 1'b1;
      for (int j = 0; j <= 6; j++) begin
         tick();
         check($sformatf("lat_in_e%0d", j), cfg_rdata[0], (j >= 6) ? 1'b1 : 1'b0);
         check($sformatf("lat_irq_e%0d", j), irq, (j >= 6) ? 1'b1 : 1'b0);
      end
      cfg_re = 1'b0;
      rd(3'd5, v);
      check("stat_rise0", v, 8'h01);

      // Rising on channel 1 (falling selected) and falling on channel 0 set nothing new
      pad_c = 8'h03;
      ticks(10);
      rd(3'd3, v);
      check("in_ch1_up", v, 8'h03);
      rd(3'd5, v);
      check("stat_ch1_up", v, 8'h01);
      pad_c = 8'h02;
      ticks(10);
      rd(3'd3, v);
      check("in_ch0_dn", v, 8'h02);
      rd(3'd5, v);
      check("stat_ch0_dn", v, 8'h01);

      // W1C in the same cycle as a new channel-0 rising event: set wins
      pad_c = 8'h03;
      ticks(5);
      cfg_addr = 3'd5; cfg_wdata = 8'h01; cfg_we = 1'b1;
      tick();
      cfg_we = 1'b0;
      check("coll_irq", irq, 1'b1);
      rd(3'd5, v);
      check("coll_stat", v, 8'h01);
      check("coll_irq2", irq, 1'b1);

      // Plain W1C: irq drops one edge later
      wr(3'd5, 8'h01);
      check("w1c_irq_hold", irq, 1'b1);
      tick();
      check("w1c_irq_drop", irq, 1'b0);
      rd(3'd5, v);
      check("w1c_stat", v, 8'h00);

      // Mid-operation reset with channel 2 count at 2
      pad_c = 8'h07;
      ticks(4);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_pad_oen", pad_oen, 8'hFF);
      check("mrst_pad_i", pad_i, 8'h00);
      check("mrst_irq", irq, 1'b0);
      // After reset T=1: d follows 3 edges after reset, seen in rdata one read later
      cfg_addr = 3'd3;
      cfg_re = 1'b1;
      for (int j = 1; j <= 6; j++) begin
         tick();
         check($sformatf("mrst_in_e%0d", j), cfg_rdata, (j >= 4) ? 8'h07 : 8'h00);
      end
      cfg_re = 1'b0;
      rd(3'd5, v);
      check("mrst_stat", v, 8'h00);
      rd(3'd6, v);
      check("mrst_edge_sel", v, 8'h00);
      rd(3'd7, v);
      check("mrst_thresh", v, 8'h00);
      check("mrst_irq_end", irq, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
